// File: rtl/gpio_safety_gate_if.sv
// Signal bundle between the system and the GPIO safety gate.
// The gate itself uses the slave modport; the system side drives through master.
interface gpio_safety_gate_if #(
  parameter int unsigned NUM_IN  = 3,
  parameter int unsigned NUM_IOS = 51
) ();
  logic [NUM_IN-1:0]  shutdown;
  logic               clear;
  logic [NUM_IOS-1:0] gpio_in;
  logic [NUM_IOS-1:0] gpio_out;
  logic [NUM_IOS-1:0] gpio_oe;
  logic               gated;
  logic [NUM_IN-1:0]  trip_cause;
  logic [7:0]         trip_count;

  modport master (
    output shutdown, clear, gpio_in,
    input  gpio_out, gpio_oe, gated, trip_cause, trip_count
  );

  modport slave (
    input  shutdown, clear, gpio_in,
    output gpio_out, gpio_oe, gated, trip_cause, trip_count
  );
endinterface

// File: rtl/gpio_safety_gate.sv
// Forces GPIO outputs to a safe value while any shutdown source is active, then releases
// them only after a programmable quiet period; latched sources need a software clear.
module gpio_safety_gate #(
  parameter int unsigned        NUM_IN         = 3,
  parameter int unsigned        NUM_IOS        = 51,
  parameter logic [NUM_IN-1:0]  LATCH_MASK     = '0,
  parameter logic [NUM_IOS-1:0] SAFE_VALUE     = '0,
  parameter int unsigned        RELEASE_CYCLES = 50000
) (
  input logic               clk,
  input logic               reset_n,
  gpio_safety_gate_if.slave bus
);

  typedef enum logic [1:0] {StRun, StSafe, StHoldoff} state_e;

  localparam int unsigned    CntW    = 20;
  localparam logic [CntW-1:0] RelLast = CntW'(RELEASE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [NUM_IN-1:0]  sync1_q, src_q;
  logic [NUM_IN-1:0]  trip_cause_q, trip_cause_d;
  logic [NUM_IN-1:0]  latch_pend_q, latch_pend_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [7:0]         trip_count_q, trip_count_d;
  logic [NUM_IOS-1:0] gpio_out_q, gpio_out_d;
  logic [NUM_IOS-1:0] gpio_oe_q, gpio_oe_d;
  logic               gated_q, gated_d;

  always_comb begin
    // Clear only drops bits whose source is quiet this cycle; an active source wins.
    trip_cause_d = bus.clear ? src_q : (trip_cause_q | src_q);
    latch_pend_d = bus.clear ? (src_q & LATCH_MASK)
                             : (latch_pend_q | (src_q & LATCH_MASK));
    state_d      = state_q;
    cnt_d        = cnt_q;
    trip_count_d = trip_count_q;

    unique case (state_q)
      StRun: begin
        if (|src_q) begin
          state_d = StSafe;
          if (trip_count_q != 8'hFF) trip_count_d = trip_count_q + 8'd1;
        end
      end
      StSafe: begin
        if (!(|src_q) && !(|latch_pend_q)) begin
          state_d = StHoldoff;
          cnt_d   = '0;
        end
      end
      StHoldoff: begin
        if (|src_q) begin
          state_d = StSafe;
        end else if (cnt_q == RelLast) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StSafe;
    endcase

    // Outputs follow the next state so they change on the same edge as the FSM.
    gated_d    = (state_d != StRun);
    gpio_out_d = gated_d ? SAFE_VALUE : bus.gpio_in;
    gpio_oe_d  = gated_d ? '0 : '1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StSafe;
      sync1_q      <= '0;
      src_q        <= '0;
      trip_cause_q <= '0;
      latch_pend_q <= '0;
      cnt_q        <= '0;
      trip_count_q <= '0;
      gpio_out_q   <= SAFE_VALUE;
      gpio_oe_q    <= '0;
      gated_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      sync1_q      <= bus.shutdown;
      src_q        <= sync1_q;
      trip_cause_q <= trip_cause_d;
      latch_pend_q <= latch_pend_d;
      cnt_q        <= cnt_d;
      trip_count_q <= trip_count_d;
      gpio_out_q   <= gpio_out_d;
      gpio_oe_q    <= gpio_oe_d;
      gated_q      <= gated_d;
    end
  end

  assign bus.gpio_out   = gpio_out_q;
  assign bus.gpio_oe    = gpio_oe_q;
  assign bus.gated      = gated_q;
  assign bus.trip_cause = trip_cause_q;
  assign bus.trip_count = trip_count_q;

endmodule

// File: tb/tb_gpio_safety_gate.sv
// Scoreboard bench for gpio_safety_gate: stimulus pushes model predictions, a monitor
// pops and compares them one cycle later.
module tb_gpio_safety_gate;
  localparam int unsigned NIn  = 3;
  localparam int unsigned NIos = 51;
  localparam int unsigned Rel  = 8;
  localparam logic [2:0]  Mask = 3'b100;
  localparam logic [50:0] Safe = '0;

  localparam int ModeRun  = 0;
  localparam int ModeSafe = 1;
  localparam int ModeHold = 2;

  typedef struct packed {
    logic        gated;
    logic [50:0] oe;
    logic [50:0] out;
    logic [2:0]  cause;
    logic [7:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  // Reference model state
  int         m_mode;
  int         m_left;
  int         m_trips;
  logic [2:0] m_cause;
  logic [2:0] m_latch;
  logic [2:0] m_pipe[$];

  gpio_safety_gate_if #(.NUM_IN(NIn), .NUM_IOS(NIos)) bus ();

  gpio_safety_gate #(
    .NUM_IN(NIn), .NUM_IOS(NIos), .LATCH_MASK(Mask), .SAFE_VALUE(Safe),
    .RELEASE_CYCLES(Rel)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = ModeSafe;
    m_left  = 0;
    m_trips = 0;
    m_cause = '0;
    m_latch = '0;
    m_pipe.delete();
    m_pipe.push_back(3'b000);
    m_pipe.push_back(3'b000);
  endtask

  // Predicts the outputs after the coming rising edge.
  task automatic model_step(input logic [2:0] sd, input logic clr, input logic [50:0] gin);
    logic [2:0] src;
    logic       quiet;
    exp_t       e;
    src   = m_pipe[0];
    quiet = (src == 3'b000);
    if (m_mode == ModeRun) begin
      if (!quiet) begin
        m_mode = ModeSafe;
        if (m_trips < 255) m_trips++;
      end
    end else if (m_mode == ModeSafe) begin
      if (quiet && m_latch == 3'b000) begin
        m_mode = ModeHold;
        m_left = Rel - 1;
      end
    end else begin
      if (!quiet) m_mode = ModeSafe;
      else if (m_left == 0) m_mode = ModeRun;
      else m_left--;
    end
    m_cause = clr ? src : (m_cause | src);
    m_latch = clr ? (src & Mask) : (m_latch | (src & Mask));
    void'(m_pipe.pop_front());
    m_pipe.push_back(sd);
    e.gated = (m_mode != ModeRun);
    e.oe    = e.gated ? '0 : '1;
    e.out   = e.gated ? Safe : gin;
    e.cause = m_cause;
    e.cnt   = 8'(m_trips);
    sb_q.push_back(e);
  endtask

  task automatic drive_step(input logic [2:0] sd, input logic clr);
    logic [50:0] gin;
    gin          = 51'({$urandom(), $urandom()});
    bus.shutdown = sd;
    bus.clear    = clr;
    bus.gpio_in  = gin;
    model_step(sd, clr, gin);
  endtask

  task automatic cyc(input logic [2:0] sd, input logic clr);
    @(negedge clk);
    drive_step(sd, clr);
  endtask

  // Asynchronous reset between edges, checked before any clock edge can act.
  task automatic do_reset();
    @(negedge clk);
    bus.shutdown = '0;
    bus.clear    = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_gated", 64'(bus.gated), 64'(1));
    chk("rst_oe", 64'(bus.gpio_oe), 64'(0));
    chk("rst_out", 64'(bus.gpio_out), 64'(Safe));
    chk("rst_cause", 64'(bus.trip_cause), 64'(0));
    chk("rst_count", 64'(bus.trip_count), 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    drive_step(3'b000, 1'b0);
  endtask

  // Monitor: every edge the DUT presents a new output set
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({bus.gated, bus.gpio_oe, bus.gpio_out, bus.trip_cause, bus.trip_count} !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got gated=%b oe=%h out=%h cause=%b cnt=%0d expected gated=%b oe=%h out=%h cause=%b cnt=%0d",
                   $time, bus.gated, bus.gpio_oe, bus.gpio_out, bus.trip_cause,
                   bus.trip_count, e.gated, e.oe, e.out, e.cause, e.cnt);
        end
      end
    end
  end

  initial begin
    bus.shutdown = '0;
    bus.clear    = 1'b0;
    bus.gpio_in  = '0;
    model_reset();
    do_reset();

    // Release from reset through a full holdoff into RUN
    repeat (15) cyc(3'b000, 1'b0);

    // Single-cycle pulse on source 0
    cyc(3'b001, 1'b0);
    repeat (15) cyc(3'b000, 1'b0);

    // Source 1 re-asserts in the middle of holdoff
    cyc(3'b001, 1'b0);
    repeat (7) cyc(3'b000, 1'b0);
    cyc(3'b010, 1'b0);
    repeat (16) cyc(3'b000, 1'b0);

    // Latched source 2: clear while active is ignored, clear after release un-gates
    cyc(3'b100, 1'b0);
    repeat (20) cyc(3'b000, 1'b0);
    cyc(3'b100, 1'b0);
    cyc(3'b100, 1'b0);
    cyc(3'b100, 1'b1);
    cyc(3'b100, 1'b0);
    repeat (6) cyc(3'b000, 1'b0);
    cyc(3'b000, 1'b1);
    repeat (14) cyc(3'b000, 1'b0);

    // Saturate the trip counter
    for (int t = 0; t < 260; t++) begin
      cyc(3'b001, 1'b0);
      repeat (12) cyc(3'b000, 1'b0);
    end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [2:0] sd;
      for (int b = 0; b < 3; b++) sd[b] = ($urandom_range(39) == 0);
      cyc(sd, $urandom_range(7) == 0);
    end

    // Settle into RUN, then reset asynchronously mid-cycle
    repeat (20) cyc(3'b000, 1'b1);
    do_reset();
    repeat (12) cyc(3'b000, 1'b0);

    @(posedge clk);
    #2;
    chk("sb_drain", 64'(sb_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
